// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode unit.
// Holds the fetch PC and issues one 16-bit read at a time to instruction
// memory (req/ack/rvalid).  Returned words go into a small FIFO of
// {pc, instr} that is presented to decode with a valid/ready handshake.
// A redirect (PC_load) reloads the PC, flushes the FIFO and discards any
// read still in flight.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ack          read request channel to instruction memory
//   imem_rvalid/rdata          read response channel
//   COMMAND/cmd_pc/cmd_valid   queue head to decode; cmd_ready pops it
//   PC_load/pc_target          redirect request and target address
//   perf_fetched/perf_bubble   saturating counters (FETCH_PERF_EN only)
//
// Optional feature: define FETCH_PERF_EN to add the performance counters.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       COMMAND,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_pc,
    input  logic              PC_load,
    input  logic [ADDR_W-1:0] pc_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubble
`endif
);

    // QDEPTH is 2 or 4, so pointers wrap naturally at their width.
    localparam int unsigned PTR_W = (QDEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_started;
    logic [15:0]       r_q_instr [QDEPTH];
    logic [ADDR_W-1:0] r_q_pc    [QDEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_req;
    logic              w_ack_fire;
    logic              w_push;
    logic              w_pop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_REQ;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake decode. Nothing is outstanding in S_REQ, so
    // the occupancy guard reduces to the queue count there.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_ack_fire  = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req      = r_started && (r_count < DEPTH_C);
                w_ack_fire = w_req && imem_ack;
                if (PC_load)         w_state_nxt = w_ack_fire ? S_DROP : S_REQ;
                else if (w_ack_fire) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_push = imem_rvalid && !PC_load;
                if (PC_load)          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                else if (imem_rvalid) w_state_nxt = S_REQ;
            end
            S_DROP: begin
                // The flushed read completes here; a redirect alone stays put.
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    assign w_pop = (r_count != '0) && cmd_ready;

    // PC, request address capture and instruction queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_pc      <= RESET_PC;
            r_req_pc  <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else begin
            r_started <= 1'b1;
            if (PC_load)         r_pc <= pc_target;
            else if (w_ack_fire) r_pc <= r_pc + ADDR_W'(1);
            if (w_ack_fire) r_req_pc <= r_pc;

            if (PC_load) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= imem_rdata;
                    r_q_pc[r_wr_ptr]    <= r_req_pc;
                    r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign COMMAND   = r_q_instr[r_rd_ptr];
    assign cmd_pc    = r_q_pc[r_rd_ptr];
    assign cmd_valid = (r_count != '0);

`ifdef FETCH_PERF_EN
    // Saturating pop and bubble counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else begin
            if (w_pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (!cmd_valid && cmd_ready && (perf_bubble != '1))
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the decode unit. It holds the PC and issues 16-bit instruction reads to instruction memory over a req/ack/rvalid handshake.
- Returned words are buffered in a small queue and presented to decode as COMMAND with a valid/ready handshake.
- Taken branches and jumps (PC_load with target from the ALU path) redirect the PC, flush the queue and discard any in-flight read.

Parameters:
- ADDR_W, 16, width of PC and instruction memory address (word addressed).
- RESET_PC, 0, PC value loaded on reset.
- QDEPTH, 2, instruction queue entries; legal values 2 or 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  ADDR_W  word address of the request; stable while imem_req=1 and imem_ack=0.
- imem_ack  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; at most one response per accepted request, no earlier than the cycle after ack.
- imem_rdata  input  16  instruction word.
- COMMAND  output  16  instruction at queue head, to decode.
- cmd_valid  output  1  COMMAND and cmd_pc valid.
- cmd_ready  input  1  decode consumes the head this cycle when cmd_valid=1.
- cmd_pc  output  ADDR_W  address of COMMAND.
- PC_load  input  1  redirect request.
- pc_target  input  ADDR_W  redirect address.

Behaviour:
- Reset (async, rst_n=0):
  - fetch PC=RESET_PC; state=REQ; queue empty; outstanding=0.
  - imem_req=0, imem_addr=RESET_PC, cmd_valid=0, COMMAND=16'h0000, cmd_pc=0.
  - First request is raised the first cycle after deassertion.
- States:
  - REQ: imem_req=1 when count+outstanding<QDEPTH, else 0. On imem_ack: outstanding=1, PC<=PC+1, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {PC_of_request, imem_rdata}, outstanding=0, go to REQ.
  - DROP: an outstanding read was flushed. On imem_rvalid: discard data, go to REQ.
- At most one outstanding read; PC increments modulo 2^ADDR_W (wrap from all-ones to 0, no flag).
- Queue: FIFO of {pc, instr}. Head is driven combinationally onto COMMAND/cmd_pc; cmd_valid = (count!=0). Pop when cmd_valid & cmd_ready.
- Push and pop in the same cycle with the queue full is legal; count is unchanged. A push never overflows because of the count+outstanding<QDEPTH guard.
- Fetch-to-COMMAND latency: one cycle after imem_rvalid (registered queue write).
- Redirect (PC_load=1), takes precedence over everything:
  - Queue cleared next cycle, cmd_valid=0 for at least that cycle; a pop coincident with PC_load is still counted as consumed by decode.
  - PC<=pc_target.
  - If the read is outstanding (WAIT), or acked this same cycle: go to DROP.
  - If imem_rvalid arrives the same cycle as PC_load: data discarded, go to REQ.
  - If in REQ with no ack: go to REQ; imem_addr switches to pc_target next cycle. This is the only case where the address changes while req is pending.
- PC_load in DROP: PC<=pc_target, remain in DROP.
- Reset mid-transaction: all state cleared. A late imem_rvalid after reset with outstanding=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (increments on each pop) and perf_bubble[31:0] (increments each cycle cmd_valid=0 && cmd_ready=1). Both are saturating, reset to 0, and cleared on rst_n only.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory acks immediately, rvalid 1 cycle later with words 16'h8001, 16'h8802; cmd_ready=1 -> COMMAND=16'h8001 with cmd_pc=0, then 16'h8802 with cmd_pc=1; imem_addr 0,1,2 in order.
- cmd_ready=0 for 6 cycles -> exactly QDEPTH=2 entries held; imem_req drops to 0 and no third ack occurs; releasing ready drains in order with no loss.
- PC_load=1, pc_target=16'h0040 while a read to 0x0005 is outstanding; rvalid returns 16'hFFFF -> 16'hFFFF never appears on COMMAND; next request addr=0x0040.
- PC_load coincident with imem_rvalid -> data dropped, cmd_valid=0 the next cycle, next imem_addr=pc_target.
- PC starting at 16'hFFFF, sequential fetch -> next imem_addr=16'h0000, cmd_pc wraps accordingly.
- rst_n pulsed low mid-WAIT -> outputs return to reset values immediately (async); a stale rvalid after release is ignored and fetch restarts at RESET_PC.
